// File: rtl/datapath_wide_if.sv
// Control-unit strobes and registered status of datapath_wide.
// The shared data bus is a separate inout port so it stays a resolved net.
interface datapath_wide_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_GP     = 8
);
  localparam int SEL_W = $clog2(NUM_GP);
  localparam int LANES = ADDR_WIDTH / DATA_WIDTH;
  localparam int LP_W  = (LANES > 1) ? $clog2(LANES) : 1;

  logic             pc_increment;
  logic             pc_set;
  logic             pc_branch;
  logic             gp_read;
  logic             gp_write;
  logic [SEL_W-1:0] gp_input_select;
  logic [SEL_W-1:0] gp_output_select;
  logic [SEL_W-1:0] gp_alu_output_select;
  logic [3:0]       alu_operation;
  logic             latch_alu;
  logic             alu_drive;
  logic             wide_load;
  logic [1:0]       wide_target;
  logic             wide_restart;
  logic             clear_conflict;

  logic [ADDR_WIDTH-1:0] pc_count;
  logic [ADDR_WIDTH-1:0] mar_value;
  logic [ADDR_WIDTH-1:0] ir_value;
  logic [2:0]            flags;
  logic [LP_W-1:0]       lane_ptr;
  logic                  wide_done;
  logic                  bus_conflict;

  modport master (
    output pc_increment, pc_set, pc_branch, gp_read, gp_write,
           gp_input_select, gp_output_select, gp_alu_output_select,
           alu_operation, latch_alu, alu_drive, wide_load, wide_target,
           wide_restart, clear_conflict,
    input  pc_count, mar_value, ir_value, flags, lane_ptr, wide_done,
           bus_conflict
  );

  modport slave (
    input  pc_increment, pc_set, pc_branch, gp_read, gp_write,
           gp_input_select, gp_output_select, gp_alu_output_select,
           alu_operation, latch_alu, alu_drive, wide_load, wide_target,
           wide_restart, clear_conflict,
    output pc_count, mar_value, ir_value, flags, lane_ptr, wide_done,
           bus_conflict
  );
endinterface

// File: rtl/datapath_wide.sv
// Shared-bus datapath: GP file, latched ALU, PC/JR/MAR/IR with a byte-lane
// load sequencer for address-width registers, and bus-contention detection.
module datapath_wide #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_GP     = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  datapath_wide_if.slave        ctl,
  inout  wire  [DATA_WIDTH-1:0] data_bus
);
  localparam int SEL_W = $clog2(NUM_GP);
  localparam int LANES = ADDR_WIDTH / DATA_WIDTH;
  localparam int LP_W  = (LANES > 1) ? $clog2(LANES) : 1;

  logic [DATA_WIDTH-1:0] gp_q [NUM_GP];
  logic [DATA_WIDTH-1:0] alu_q;
  logic [2:0]            flags_q;
  logic [ADDR_WIDTH-1:0] pc_q, jr_q, mar_q, ir_q;
  logic [LP_W-1:0]       lane_ptr_q;
  logic [1:0]            last_target_q;
  logic                  done_q, conflict_q;

  logic                  gp_drv, alu_drv, contention;
  logic [DATA_WIDTH-1:0] op_a, op_b, alu_res;
  logic                  alu_carry;

  logic [LP_W-1:0]       eff_ptr;
  logic                  do_load, last_lane;
  int unsigned           shamt;
  logic [ADDR_WIDTH-1:0] lane_mask, lane_data;

  // Both sources requested: nobody drives, the conflict is recorded instead.
  assign contention = ctl.gp_read & ctl.alu_drive;
  assign gp_drv     = ctl.gp_read & ~ctl.alu_drive;
  assign alu_drv    = ctl.alu_drive & ~ctl.gp_read;
  assign data_bus   = gp_drv  ? gp_q[ctl.gp_output_select] :
                      alu_drv ? alu_q : 'z;

  always_comb begin
    op_a      = gp_q[ctl.gp_alu_output_select];
    op_b      = data_bus;
    alu_res   = '0;
    alu_carry = 1'b0;
    case (ctl.alu_operation)
      4'd0:  {alu_carry, alu_res} = {1'b0, op_a} + {1'b0, op_b};
      4'd1:  {alu_carry, alu_res} = {1'b0, op_a} - {1'b0, op_b};
      4'd2:  alu_res = op_a & op_b;
      4'd3:  alu_res = op_a | op_b;
      4'd4:  alu_res = op_a ^ op_b;
      4'd5:  alu_res = ~op_a;
      4'd6:  {alu_carry, alu_res} = {op_a, 1'b0};
      4'd7:  {alu_res, alu_carry} = {1'b0, op_a};
      4'd8:  alu_res = op_b;
      4'd9:  {alu_carry, alu_res} = {1'b0, op_a} + (DATA_WIDTH + 1)'(1);
      4'd10: {alu_carry, alu_res} = {1'b0, op_a} - (DATA_WIDTH + 1)'(1);
      default: begin
        alu_res   = '0;
        alu_carry = 1'b0;
      end
    endcase
  end

  // A target switch mid-sequence restarts at lane 0 of the new target.
  always_comb begin
    eff_ptr   = (lane_ptr_q != '0 && ctl.wide_target != last_target_q) ? '0 : lane_ptr_q;
    do_load   = ctl.wide_load & ~ctl.wide_restart & (ctl.wide_target != 2'b11);
    last_lane = (eff_ptr == LP_W'(LANES - 1));
    shamt     = 32'(eff_ptr) * DATA_WIDTH;
    lane_mask = ADDR_WIDTH'({DATA_WIDTH{1'b1}}) << shamt;
    lane_data = ADDR_WIDTH'(data_bus) << shamt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_GP; i++) gp_q[i] <= '0;
      alu_q         <= '0;
      flags_q       <= '0;
      pc_q          <= '0;
      jr_q          <= '0;
      mar_q         <= '0;
      ir_q          <= '0;
      lane_ptr_q    <= '0;
      last_target_q <= '0;
      done_q        <= 1'b0;
      conflict_q    <= 1'b0;
    end else begin
      if (ctl.gp_write) gp_q[ctl.gp_input_select] <= data_bus;
      if (ctl.latch_alu) begin
        alu_q   <= alu_res;
        flags_q <= {alu_carry, alu_res == '0, alu_res[DATA_WIDTH-1]};
      end
      conflict_q <= contention | (conflict_q & ~ctl.clear_conflict);
      done_q     <= do_load & last_lane;

      if (ctl.wide_restart) begin
        lane_ptr_q <= '0;
      end else if (do_load) begin
        lane_ptr_q    <= last_lane ? '0 : eff_ptr + LP_W'(1);
        last_target_q <= ctl.wide_target;
        case (ctl.wide_target)
          2'b00:   jr_q  <= (jr_q  & ~lane_mask) | (lane_data & lane_mask);
          2'b01:   mar_q <= (mar_q & ~lane_mask) | (lane_data & lane_mask);
          default: ir_q  <= (ir_q  & ~lane_mask) | (lane_data & lane_mask);
        endcase
      end

      if (ctl.pc_set)            pc_q <= jr_q;
      else if (ctl.pc_branch)    pc_q <= pc_q + ADDR_WIDTH'($signed(data_bus));
      else if (ctl.pc_increment) pc_q <= pc_q + ADDR_WIDTH'(1);
    end
  end

  assign ctl.pc_count     = pc_q;
  assign ctl.mar_value    = mar_q;
  assign ctl.ir_value     = ir_q;
  assign ctl.flags        = flags_q;
  assign ctl.lane_ptr     = lane_ptr_q;
  assign ctl.wide_done    = done_q;
  assign ctl.bus_conflict = conflict_q;
endmodule

// File: tb/tb_datapath_wide.sv
// Directed bench for datapath_wide: default 16-bit instance plus a 32-bit
// address instance for the four-lane load sequence.
module tb_datapath_wide;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int tests_run    = 0;
  int tests_failed = 0;

  datapath_wide_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .NUM_GP(8)) if0 ();
  datapath_wide_if #(.DATA_WIDTH(8), .ADDR_WIDTH(32), .NUM_GP(8)) if1 ();

  wire  [7:0] bus0, bus1;
  logic [7:0] tb_bus0 = '0, tb_bus1 = '0;
  logic       tb_drv0 = 1'b0, tb_drv1 = 1'b0;
  assign bus0 = tb_drv0 ? tb_bus0 : 'z;
  assign bus1 = tb_drv1 ? tb_bus1 : 'z;

  datapath_wide #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .NUM_GP(8)) u_dut16 (
    .clock(clock), .reset(reset), .ctl(if0), .data_bus(bus0)
  );
  datapath_wide #(.DATA_WIDTH(8), .ADDR_WIDTH(32), .NUM_GP(8)) u_dut32 (
    .clock(clock), .reset(reset), .ctl(if1), .data_bus(bus1)
  );

  typedef struct {
    logic [3:0] op;
    logic [7:0] b;
    logic [7:0] res;
    logic [2:0] flg;
  } alu_vec_t;

  // Operand A is always reg2 = 0xF0; flags are {C, Z, N}.
  alu_vec_t alu_vecs[12] = '{
    '{4'd0,  8'h20, 8'h10, 3'b100},
    '{4'd1,  8'hF0, 8'h00, 3'b010},
    '{4'd1,  8'hF1, 8'hFF, 3'b101},
    '{4'd2,  8'h3C, 8'h30, 3'b000},
    '{4'd4,  8'hFF, 8'h0F, 3'b000},
    '{4'd5,  8'h00, 8'h0F, 3'b000},
    '{4'd6,  8'h00, 8'hE0, 3'b101},
    '{4'd7,  8'h00, 8'h78, 3'b000},
    '{4'd8,  8'h80, 8'h80, 3'b001},
    '{4'd9,  8'h00, 8'hF1, 3'b001},
    '{4'd10, 8'h00, 8'hEF, 3'b001},
    '{4'd12, 8'h55, 8'h00, 3'b010}
  };

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_strobes();
    if0.pc_increment = 0; if0.pc_set = 0; if0.pc_branch = 0;
    if0.gp_read = 0; if0.gp_write = 0; if0.latch_alu = 0; if0.alu_drive = 0;
    if0.wide_load = 0; if0.wide_restart = 0; if0.clear_conflict = 0;
    if1.pc_increment = 0; if1.pc_set = 0; if1.pc_branch = 0;
    if1.gp_read = 0; if1.gp_write = 0; if1.latch_alu = 0; if1.alu_drive = 0;
    if1.wide_load = 0; if1.wide_restart = 0; if1.clear_conflict = 0;
    tb_drv0 = 0; tb_drv1 = 0;
  endtask

  task automatic wload0(input logic [1:0] tgt, input logic [7:0] v);
    if0.wide_target = tgt; tb_bus0 = v; tb_drv0 = 1; if0.wide_load = 1;
    tick();
    if0.wide_load = 0; tb_drv0 = 0;
  endtask

  initial begin
    clear_strobes();
    if0.gp_input_select = '0; if0.gp_output_select = '0; if0.gp_alu_output_select = '0;
    if0.alu_operation = '0; if0.wide_target = '0;
    if1.gp_input_select = '0; if1.gp_output_select = '0; if1.gp_alu_output_select = '0;
    if1.alu_operation = '0; if1.wide_target = '0;
    tick(); tick();
    check("rst_pc", if0.pc_count, 0);
    check("rst_mar", if0.mar_value, 0);
    check("rst_flags", if0.flags, 0);
    check("rst_ptr", if0.lane_ptr, 0);
    check("rst_done", if0.wide_done, 0);
    reset = 0;

    // Two-lane MAR load
    wload0(2'b01, 8'h34);
    check("mar_l0", if0.mar_value, 16'h0034);
    check("mar_ptr1", if0.lane_ptr, 1);
    check("mar_done_early", if0.wide_done, 0);
    wload0(2'b01, 8'h12);
    check("mar_full", if0.mar_value, 16'h1234);
    check("mar_ptr0", if0.lane_ptr, 0);
    check("mar_done", if0.wide_done, 1);
    tick();
    check("mar_done_pulse", if0.wide_done, 0);

    // PC from JR, branch, increment, priority and wrap
    wload0(2'b00, 8'hEF); wload0(2'b00, 8'hBE);
    if0.pc_set = 1; tick(); if0.pc_set = 0;
    check("pc_set", if0.pc_count, 16'hBEEF);
    tb_bus0 = 8'hFE; tb_drv0 = 1; if0.pc_branch = 1; tick(); clear_strobes();
    check("pc_branch_neg", if0.pc_count, 16'hBEED);
    if0.pc_increment = 1; tick(); clear_strobes();
    check("pc_inc", if0.pc_count, 16'hBEEE);
    wload0(2'b00, 8'hFF); wload0(2'b00, 8'hFF);
    tb_bus0 = 8'h05; tb_drv0 = 1;
    if0.pc_set = 1; if0.pc_branch = 1; if0.pc_increment = 1; tick(); clear_strobes();
    check("pc_prio_set", if0.pc_count, 16'hFFFF);
    if0.pc_increment = 1; tick(); clear_strobes();
    check("pc_inc_wrap", if0.pc_count, 16'h0000);
    tb_bus0 = 8'hFF; tb_drv0 = 1; if0.pc_branch = 1; if0.pc_increment = 1; tick(); clear_strobes();
    check("pc_branch_wrap", if0.pc_count, 16'hFFFF);
    if0.wide_target = 2'b00; tb_bus0 = 8'h00; tb_drv0 = 1; if0.wide_load = 1; if0.pc_set = 1;
    tick(); clear_strobes();
    check("pc_set_old_jr", if0.pc_count, 16'hFFFF);
    if0.wide_restart = 1; tick(); clear_strobes();
    check("restart_ptr", if0.lane_ptr, 0);
    if0.pc_set = 1; tick(); clear_strobes();
    check("pc_set_new_jr", if0.pc_count, 16'hFF00);

    // GP file and ALU
    if0.gp_input_select = 3'd2; tb_bus0 = 8'hF0; tb_drv0 = 1; if0.gp_write = 1;
    tick(); clear_strobes();
    if0.gp_output_select = 3'd2; if0.gp_read = 1; #1;
    check("gp_read_r2", bus0, 8'hF0);
    if0.gp_input_select = 3'd3; if0.gp_write = 1; tick(); clear_strobes();
    if0.gp_output_select = 3'd3; if0.gp_read = 1; #1;
    check("gp_move_r3", bus0, 8'hF0);
    clear_strobes();
    if0.gp_alu_output_select = 3'd2;
    foreach (alu_vecs[i]) begin
      if0.alu_operation = alu_vecs[i].op; tb_bus0 = alu_vecs[i].b; tb_drv0 = 1;
      if0.latch_alu = 1; tick(); clear_strobes();
      if0.alu_operation = 4'd3;
      check($sformatf("alu%0d_flags", i), if0.flags, alu_vecs[i].flg);
      if0.alu_drive = 1; #1;
      check($sformatf("alu%0d_res", i), bus0, alu_vecs[i].res);
      if0.alu_drive = 0; #1;
    end

    // Bus contention
    check("conf_idle", if0.bus_conflict, 0);
    if0.gp_output_select = 3'd2; if0.gp_read = 1; if0.alu_drive = 1;
    tb_bus0 = 8'h5A; tb_drv0 = 1; #1;
    check("conf_released", bus0, 8'h5A);
    tick(); clear_strobes();
    check("conf_set", if0.bus_conflict, 1);
    tick();
    check("conf_sticky", if0.bus_conflict, 1);
    if0.gp_read = 1; if0.alu_drive = 1; if0.clear_conflict = 1; tick(); clear_strobes();
    check("conf_clear_vs_new", if0.bus_conflict, 1);
    if0.clear_conflict = 1; tick(); clear_strobes();
    check("conf_cleared", if0.bus_conflict, 0);

    // Restart priority and reserved target
    wload0(2'b01, 8'h11);
    check("rs_l0", if0.mar_value, 16'h1211);
    if0.wide_restart = 1; wload0(2'b01, 8'h22); clear_strobes();
    check("rs_nowrite", if0.mar_value, 16'h1211);
    check("rs_ptr", if0.lane_ptr, 0);
    check("rs_nodone", if0.wide_done, 0);
    wload0(2'b01, 8'h33); wload0(2'b01, 8'h44);
    check("rs_reload", if0.mar_value, 16'h4433);
    wload0(2'b11, 8'h99);
    check("rsv_ptr", if0.lane_ptr, 0);
    check("rsv_done", if0.wide_done, 0);
    check("rsv_mar", if0.mar_value, 16'h4433);

    // Target switch mid-sequence, then reset during the second lane
    wload0(2'b01, 8'hAA);
    check("sw_mar", if0.mar_value, 16'h44AA);
    wload0(2'b10, 8'h55);
    check("sw_ir", if0.ir_value, 16'h0055);
    check("sw_ptr", if0.lane_ptr, 1);
    check("sw_mar_kept", if0.mar_value, 16'h44AA);
    if0.wide_target = 2'b10; tb_bus0 = 8'h66; tb_drv0 = 1; if0.wide_load = 1;
    #2 reset = 1;
    #1;
    check("ar_pc", if0.pc_count, 0);
    check("ar_mar", if0.mar_value, 0);
    check("ar_ir", if0.ir_value, 0);
    check("ar_ptr", if0.lane_ptr, 0);
    tick();
    check("ar_done", if0.wide_done, 0);
    check("ar_ir_hold", if0.ir_value, 0);
    clear_strobes();
    reset = 0;

    // 32-bit address instance: four lanes
    begin
      logic [7:0] bytes4 [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
      for (int k = 0; k < 4; k++) begin
        if1.wide_target = 2'b10; tb_bus1 = bytes4[k]; tb_drv1 = 1; if1.wide_load = 1;
        tick(); clear_strobes();
        check($sformatf("w32_done%0d", k), if1.wide_done, (k == 3) ? 1 : 0);
        check($sformatf("w32_ptr%0d", k), if1.lane_ptr, (k + 1) % 4);
      end
      check("w32_ir", if1.ir_value, 32'h12345678);
      tick();
      check("w32_done_pulse", if1.wide_done, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1);
  end
endmodule

// File: doc/datapath_wide.md
# datapath_wide

Parametrised datapath: general-purpose register file, ALU with result latch, program counter, and address-width jump, memory-address and instruction registers, all on one shared bidirectional data bus. Replaces fixed high/low byte strobes with a byte-lane load sequencer, so any ADDR_WIDTH that is a multiple of DATA_WIDTH loads over a narrow bus. Adds PC-relative branching and bus-contention detection. Driven cycle-by-cycle by the control unit.

## Interface
Parameters:
- DATA_WIDTH, 8, data bus / GP register / ALU width (≥4)
- ADDR_WIDTH, 16, PC/JR/MAR/IR width; must be an integer multiple of DATA_WIDTH
- NUM_GP, 8, GP register count (power of two, ≥2); SEL_W = clog2(NUM_GP)
- LANES (derived), ADDR_WIDTH/DATA_WIDTH; LP_W = max(1, clog2(LANES))

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- pc_increment  in  1  PC += 1
- pc_set  in  1  PC <= JR
- pc_branch  in  1  PC += sign-extended data_bus
- gp_read  in  1  GP file drives data_bus with reg[gp_output_select]
- gp_write  in  1  reg[gp_input_select] <= data_bus
- gp_input_select  in  SEL_W  write index
- gp_output_select  in  SEL_W  bus-read index
- gp_alu_output_select  in  SEL_W  ALU operand A index
- alu_operation  in  4  ALU opcode
- latch_alu  in  1  capture ALU result and flags
- alu_drive  in  1  latched result drives data_bus
- wide_load  in  1  write data_bus into current lane of wide target
- wide_target  in  2  00 JR, 01 MAR, 10 IR, 11 reserved (no write, pointer unchanged)
- wide_restart  in  1  lane pointer <= 0
- clear_conflict  in  1  clears bus_conflict
- pc_count  out  ADDR_WIDTH  program counter
- mar_value  out  ADDR_WIDTH  memory address register
- ir_value  out  ADDR_WIDTH  instruction register
- flags  out  3  latched {carry, zero, negative}
- lane_ptr  out  LP_W  next lane to be written
- wide_done  out  1  one-cycle pulse after the final lane is written
- bus_conflict  out  1  sticky contention flag
- data_bus  inout  DATA_WIDTH  shared bus

## Operation
- Reset: PC, JR, MAR, IR, all GP registers, ALU latch, flags, lane_ptr = 0; wide_done = 0; bus_conflict = 0; data_bus released (Z).
- Bus drive: gp_read alone → GP value; alu_drive alone → latched result; both → neither drives (Z) and bus_conflict is set on the next edge. Otherwise Z. Combinational drive, same cycle.
- bus_conflict stays set until clear_conflict; if clear_conflict and a new conflict occur in the same cycle, the flag stays set.
- GP file: write on edge; read-during-write of the same index returns the old value.
- ALU: A = reg[gp_alu_output_select], B = data_bus. Ops: 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL A, 7 SHR A (logical), 8 PASS B, 9 INC A, 10 DEC A; 11–15 → result 0, carry 0. Carry = carry-out for ADD/INC, borrow for SUB/DEC, shifted-out bit for SHL/SHR, else 0. Zero = (result == 0). Negative = result MSB.
- latch_alu: result and flags captured on edge; held otherwise.
- Wide load: on wide_load with a valid target, lane[lane_ptr] (bits lane_ptr*DATA_WIDTH upward) of the target <= data_bus; other lanes hold. lane_ptr increments; from LANES−1 it wraps to 0 and wide_done pulses the next cycle. LANES = 1: every load pulses wide_done.
- If wide_target changes while lane_ptr ≠ 0, that load writes lane 0 of the new target and lane_ptr becomes 1 (abandoned partial load is not undone).
- wide_restart has priority over wide_load: pointer → 0, no write that cycle.
- PC priority: pc_set > pc_branch > pc_increment. All arithmetic modulo 2^ADDR_WIDTH (wraps; 0 − 1 → all ones).
- pc_set with a same-cycle JR lane write uses the pre-edge JR value.

## Timing
- Register updates take effect the edge after the strobe; outputs are registered except data_bus.
- ALU is combinational; operands must be stable in the latch_alu cycle.
- Reset asserted mid-sequence aborts it immediately: lane_ptr = 0, partial registers cleared, wide_done not asserted.
- Any strobe combination is legal; effects are as defined above.

## Test plan
- Default params: reset, then 2× wide_load to MAR with 0x34, 0x12 → mar_value = 0x1234, lane_ptr 0, wide_done pulses once after the 2nd load.
- JR ← 0xBEEF, pc_set → pc_count = 0xBEEF; pc_branch with bus 0xFE → 0xBEED; PC = 0xFFFF + pc_increment → 0x0000.
- reg2 = 0xF0, bus 0x20, ADD, latch → result 0x10, flags C=1 Z=0 N=0; SUB reg2 − 0xF0 → 0x00, Z=1.
- gp_read and alu_drive together → data_bus Z, bus_conflict = 1 until clear_conflict.
- Load MAR lane 0, switch target to IR → IR lane 0 written, lane_ptr = 1; assert reset during 2nd lane → all outputs 0.
- DATA_WIDTH=8, ADDR_WIDTH=32: four loads 0x78,0x56,0x34,0x12 into IR → 0x12345678, wide_done after the 4th only.
